// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM AXI read arbiter.
// - ar_state_e : AR channel FSM state (StIdle = no address held, StAddr = address presented)
// - req_id_t   : requester id stored in the ordering FIFO (ID_M0 = display, ID_M1 = secondary)
package sram_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StAddr = 1'b1
  } ar_state_e;

  localparam int unsigned ID_WIDTH = 1;

  typedef logic [ID_WIDTH-1:0] req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data (o_rd_data is the current head).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset (empties the FIFO)
//   i_wr_en / i_wr_data   : push, ignored when full
//   i_rd_en               : pop, ignored when empty
//   o_rd_data             : head entry, valid when !o_empty
//   o_full / o_empty      : status
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [ADDR_SIZE:0]    r_wr_ptr;
  logic [ADDR_SIZE:0]    r_rd_ptr;
  logic                  w_wr;
  logic                  w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_SIZE] != r_rd_ptr[ADDR_SIZE]) &&
                   (r_wr_ptr[ADDR_SIZE-1:0] == r_rd_ptr[ADDR_SIZE-1:0]);
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_SIZE-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[ADDR_SIZE-1:0]];

endmodule

// File: rtl/sram_axi_rd_arb.sv
// Two-requester AXI read arbiter in front of a single SRAM AXI read port.
// m0 (display stream) has priority; m1 is forced through after STARVE_LIMIT consecutive m0
// grants while it waits. Granted requester ids are queued so R beats are routed back in
// grant order.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   m{0,1}_ar{addr,valid,ready}   : requester AR channels
//   m{0,1}_r{data,resp,valid,ready}: requester R channels (data/resp broadcast)
//   sram_axi_ar*                  : shared SRAM AR channel
//   sram_axi_r*                   : shared SRAM R channel
module sram_axi_rd_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 20,
  parameter int unsigned AXI_DATA_WIDTH  = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_araddr,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  output logic [AXI_DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]                m0_rresp,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_araddr,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  output logic [AXI_DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]                m1_rresp,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
  output logic                      sram_axi_arvalid,
  input  logic                      sram_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
  input  logic [1:0]                sram_axi_rresp,
  input  logic                      sram_axi_rvalid,
  output logic                      sram_axi_rready
);

  localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  ar_state_e                 r_state;
  ar_state_e                 w_state_d;
  logic [CNT_W-1:0]          r_outstanding;
  logic [STARVE_W-1:0]       r_starve_cnt;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;

  logic    w_fifo_full;
  logic    w_fifo_empty;
  req_id_t w_head_id;
  req_id_t w_grant_id;
  logic    w_head_is_m1;
  logic    w_pick_m1;
  logic    w_grant_m0;
  logic    w_grant_m1;
  logic    w_grant;
  logic    w_r_pop;

  // m1 wins only when m0 is idle or m1 has waited through STARVE_LIMIT m0 grants.
  assign w_pick_m1 = m1_arvalid &&
                     (!m0_arvalid || (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));

  always_comb begin
    w_state_d  = r_state;
    w_grant_m0 = 1'b0;
    w_grant_m1 = 1'b0;
    unique case (r_state)
      StIdle: begin
        // rst_n gating keeps arready low while reset is held, even with arvalid high.
        if (rst_n && (r_outstanding < CNT_W'(MAX_OUTSTANDING)) && !w_fifo_full) begin
          if (w_pick_m1) begin
            w_grant_m1 = 1'b1;
          end else if (m0_arvalid) begin
            w_grant_m0 = 1'b1;
          end
        end
        if (w_grant_m0 || w_grant_m1) w_state_d = StAddr;
      end
      StAddr: begin
        if (sram_axi_arready) w_state_d = StIdle;
      end
    endcase
  end

  assign w_grant    = w_grant_m0 | w_grant_m1;
  assign w_grant_id = w_grant_m1 ? ID_M1 : ID_M0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_araddr      <= '0;
      r_outstanding <= '0;
      r_starve_cnt  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) r_araddr <= w_grant_m1 ? m1_araddr : m0_araddr;
      if (w_grant && !w_r_pop) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_grant && w_r_pop) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
      if (w_grant_m1 || !m1_arvalid) begin
        r_starve_cnt <= '0;
      end else if (w_grant_m0 && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH (ID_WIDTH),
    .ADDR_SIZE  (PTR_W)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_grant),
    .i_wr_data (w_grant_id),
    .i_rd_en   (w_r_pop),
    .o_rd_data (w_head_id),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign m0_arready       = w_grant_m0;
  assign m1_arready       = w_grant_m1;
  assign sram_axi_arvalid = (r_state == StAddr);
  assign sram_axi_araddr  = r_araddr;

  // Empty FIFO blocks rready so stray or post-reset responses are never consumed.
  assign w_head_is_m1    = (w_head_id == ID_M1);
  assign sram_axi_rready = ~w_fifo_empty & (w_head_is_m1 ? m1_rready : m0_rready);
  assign m0_rvalid       = sram_axi_rvalid & ~w_fifo_empty & ~w_head_is_m1;
  assign m1_rvalid       = sram_axi_rvalid & ~w_fifo_empty & w_head_is_m1;
  assign w_r_pop         = sram_axi_rvalid & sram_axi_rready;

  assign m0_rdata = sram_axi_rdata;
  assign m1_rdata = sram_axi_rdata;
  assign m0_rresp = sram_axi_rresp;
  assign m1_rresp = sram_axi_rresp;

endmodule

// File: tb/tb_sram_axi_rd_arb.sv
// Scoreboard bench for sram_axi_rd_arb: tests push expected AR addresses and R beats into
// queues; a negedge monitor pops and compares whenever the DUT hands something over.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_sram_axi_rd_arb;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m0_araddr, m1_araddr, sram_axi_araddr;
  logic          m0_arvalid, m0_arready, m1_arvalid, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, sram_axi_rdata;
  logic [1:0]    m0_rresp, m1_rresp, sram_axi_rresp;
  logic          m0_rvalid, m0_rready, m1_rvalid, m1_rready;
  logic          sram_axi_arvalid, sram_axi_arready;
  logic          sram_axi_rvalid, sram_axi_rready;

  sram_axi_rd_arb #(
    .AXI_ADDR_WIDTH  (AW),
    .AXI_DATA_WIDTH  (DW),
    .MAX_OUTSTANDING (4),
    .STARVE_LIMIT    (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_araddr        (m0_araddr),
    .m0_arvalid       (m0_arvalid),
    .m0_arready       (m0_arready),
    .m0_rdata         (m0_rdata),
    .m0_rresp         (m0_rresp),
    .m0_rvalid        (m0_rvalid),
    .m0_rready        (m0_rready),
    .m1_araddr        (m1_araddr),
    .m1_arvalid       (m1_arvalid),
    .m1_arready       (m1_arready),
    .m1_rdata         (m1_rdata),
    .m1_rresp         (m1_rresp),
    .m1_rvalid        (m1_rvalid),
    .m1_rready        (m1_rready),
    .sram_axi_araddr  (sram_axi_araddr),
    .sram_axi_arvalid (sram_axi_arvalid),
    .sram_axi_arready (sram_axi_arready),
    .sram_axi_rdata   (sram_axi_rdata),
    .sram_axi_rresp   (sram_axi_rresp),
    .sram_axi_rvalid  (sram_axi_rvalid),
    .sram_axi_rready  (sram_axi_rready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   rdy;
  } pend_t;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   cyc = 0;
  logic [AW-1:0] req0_q[$], req1_q[$], exp_ar_q[$];
  logic [DW+1:0] exp_r0_q[$], exp_r1_q[$];
  pend_t         sram_pend_q[$];
  bit            grant_log[$];
  bit            r_order_q[$];
  int unsigned   grant_cyc_q[$], pop_cyc_q[$];
  bit            hs0 = 0, hs1 = 0, sram_r_hs = 0;
  bit            arready_en = 0, rvalid_en = 0;
  int unsigned   m1_rv_cnt = 0, m0_beats = 0;

  // SRAM content model: {rresp, rdata} derived from the address.
  function automatic logic [DW+1:0] beat(input logic [AW-1:0] a);
    return {a[1:0], a[15:0] ^ 16'h5A5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int unsigned max);
    int unsigned n = 0;
    while ((req0_q.size() + req1_q.size() + exp_ar_q.size() + exp_r0_q.size() +
            exp_r1_q.size() + sram_pend_q.size()) != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) fail({name, "_timeout"}, n, max);
    tick();
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester and SRAM drivers.
  always @(posedge clk) begin
    #1;
    if (hs0 && req0_q.size() != 0) void'(req0_q.pop_front());
    if (hs1 && req1_q.size() != 0) void'(req1_q.pop_front());
    m0_arvalid = (req0_q.size() != 0);
    m0_araddr  = m0_arvalid ? req0_q[0] : '0;
    m1_arvalid = (req1_q.size() != 0);
    m1_araddr  = m1_arvalid ? req1_q[0] : '0;
    if (sram_r_hs && sram_pend_q.size() != 0) void'(sram_pend_q.pop_front());
    sram_axi_arready = arready_en;
    if (rvalid_en && sram_pend_q.size() != 0 && sram_pend_q[0].rdy <= cyc) begin
      sram_axi_rvalid = 1'b1;
      {sram_axi_rresp, sram_axi_rdata} = beat(sram_pend_q[0].addr);
    end else begin
      sram_axi_rvalid = 1'b0;
      {sram_axi_rresp, sram_axi_rdata} = '0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    hs0       = m0_arvalid & m0_arready;
    hs1       = m1_arvalid & m1_arready;
    sram_r_hs = sram_axi_rvalid & sram_axi_rready;
    if (hs0) begin grant_log.push_back(1'b0); grant_cyc_q.push_back(cyc); end
    if (hs1) begin grant_log.push_back(1'b1); grant_cyc_q.push_back(cyc); end
    if (sram_axi_arvalid && sram_axi_arready) begin
      if (exp_ar_q.size() == 0) fail("ar_unexpected", sram_axi_araddr, 0);
      else chk("ar_addr", sram_axi_araddr, exp_ar_q.pop_front());
      sram_pend_q.push_back('{addr: sram_axi_araddr, rdy: cyc + 2});
    end
    if (sram_r_hs) pop_cyc_q.push_back(cyc);
    if (m1_rvalid) m1_rv_cnt++;
    if (m0_rvalid && m0_rready) begin
      r_order_q.push_back(1'b0);
      m0_beats++;
      if (exp_r0_q.size() == 0) fail("m0_r_unexpected", {m0_rresp, m0_rdata}, 0);
      else chk("m0_beat", {m0_rresp, m0_rdata}, exp_r0_q.pop_front());
    end
    if (m1_rvalid && m1_rready) begin
      r_order_q.push_back(1'b1);
      if (exp_r1_q.size() == 0) fail("m1_r_unexpected", {m1_rresp, m1_rdata}, 0);
      else chk("m1_beat", {m1_rresp, m1_rdata}, exp_r1_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned n;
    rst_n = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    // m0 requests are already pending during reset; nothing may be granted yet.
    req0_q = '{20'h00010, 20'h00011, 20'h00012};
    exp_ar_q = '{20'h00010, 20'h00011, 20'h00012};
    exp_r0_q = '{beat(20'h00010), beat(20'h00011), beat(20'h00012)};
    arready_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m0_arvalid_seen", m0_arvalid, 1);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_sram_arvalid", sram_axi_arvalid, 0);
    chk("rst_sram_rready", sram_axi_rready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);

    // m0 only, three reads, 2-cycle SRAM latency.
    tick();
    rst_n = 1'b1;
    rvalid_en = 1'b1;
    base = m1_rv_cnt;
    wait_drain("t1", 100);
    chk("t1_m0_beats", m0_beats, 3);
    chk("t1_m1_rvalid_cnt", m1_rv_cnt - base, 0);

    // Both requesters continuously valid: 8 m0 grants then 1 m1, repeating.
    grant_log.delete();
    for (int i = 0; i < 18; i++) begin
      req0_q.push_back(AW'(32'h100 + i));
      exp_r0_q.push_back(beat(AW'(32'h100 + i)));
    end
    req1_q = '{20'h00200, 20'h00201};
    exp_r1_q = '{beat(20'h00200), beat(20'h00201)};
    for (int i = 0; i < 18; i++) begin
      exp_ar_q.push_back(AW'(32'h100 + i));
      if (i == 7) exp_ar_q.push_back(20'h00200);
      if (i == 15) exp_ar_q.push_back(20'h00201);
    end
    wait_drain("t2", 400);
    chk("t2_grant_cnt", grant_log.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < grant_log.size()) chk($sformatf("t2_grant_%0d", i), grant_log[i],
                                    (i == 8 || i == 17) ? 1 : 0);
    end

    // SRAM responses stalled: only MAX_OUTSTANDING grants.
    rvalid_en = 1'b0;
    grant_log.delete();
    grant_cyc_q.delete();
    pop_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      req0_q.push_back(AW'(32'h300 + i));
      exp_r0_q.push_back(beat(AW'(32'h300 + i)));
      if (i < 4) exp_ar_q.push_back(AW'(32'h300 + i));
    end
    repeat (30) @(negedge clk);
    chk("t3_grant_cnt", grant_log.size(), 4);
    chk("t3_m0_arready_blocked", m0_arready, 0);
    chk("t3_sram_arvalid", sram_axi_arvalid, 0);
    tick();
    exp_ar_q.push_back(20'h00304);
    rvalid_en = 1'b1;
    wait_drain("t3", 100);
    if (grant_cyc_q.size() >= 5 && pop_cyc_q.size() >= 1)
      chk("t3_5th_after_pop", grant_cyc_q[4] > pop_cyc_q[0], 1);
    else
      fail("t3_event_count", grant_cyc_q.size(), 5);

    // Grant order m1 then m0; m1 holds rready low.
    r_order_q.delete();
    m1_rready = 1'b0;
    req1_q.push_back(20'h00400);
    exp_r1_q.push_back(beat(20'h00400));
    exp_ar_q.push_back(20'h00400);
    exp_ar_q.push_back(20'h00401);
    tick();
    req0_q.push_back(20'h00401);
    exp_r0_q.push_back(beat(20'h00401));
    n = 0;
    do begin @(negedge clk); n++; end while (!sram_axi_rvalid && n < 30);
    if (n >= 30) fail("t4_rvalid_timeout", n, 30);
    for (int i = 0; i < 3; i++) begin
      chk("t4_sram_rready", sram_axi_rready, 0);
      chk("t4_m1_rvalid", m1_rvalid, 1);
      chk("t4_m0_rvalid", m0_rvalid, 0);
      @(negedge clk);
    end
    tick();
    m1_rready = 1'b1;
    wait_drain("t4", 100);
    chk("t4_order_cnt", r_order_q.size(), 2);
    if (r_order_q.size() == 2) begin
      chk("t4_first_m1", r_order_q[0], 1);
      chk("t4_second_m0", r_order_q[1], 0);
    end

    // Reset with two reads outstanding; late responses must not be taken.
    rvalid_en = 1'b0;
    req0_q = '{20'h00500, 20'h00501};
    exp_ar_q = '{20'h00500, 20'h00501};
    exp_r0_q = '{beat(20'h00500), beat(20'h00501)};
    n = 0;
    while (exp_ar_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) fail("t5_ar_timeout", n, 30);
    tick();
    chk("t5_pre_rready", sram_axi_rready, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rready", sram_axi_rready, 0);
    chk("t5_rst_arvalid", sram_axi_arvalid, 0);
    chk("t5_rst_m0_rvalid", m0_rvalid, 0);
    chk("t5_rst_m1_rvalid", m1_rvalid, 0);
    exp_r0_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    rvalid_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_stale_rvalid_seen", sram_axi_rvalid, 1);
      chk("t5_stale_rready", sram_axi_rready, 0);
      chk("t5_stale_m0_rvalid", m0_rvalid, 0);
    end
    tick();
    sram_pend_q.delete();
    tick();

    // SRAM arready held low: address stable, no further grant.
    arready_en = 1'b0;
    tick();
    req0_q = '{20'h00600, 20'h00601};
    exp_ar_q = '{20'h00600, 20'h00601};
    exp_r0_q = '{beat(20'h00600), beat(20'h00601)};
    n = 0;
    do begin @(negedge clk); n++; end while (!sram_axi_arvalid && n < 20);
    if (n >= 20) fail("t6_arvalid_timeout", n, 20);
    for (int i = 0; i < 4; i++) begin
      chk("t6_arvalid", sram_axi_arvalid, 1);
      chk("t6_araddr", sram_axi_araddr, 20'h00600);
      chk("t6_m0_arready", m0_arready, 0);
      if (i < 3) @(negedge clk);
    end
    tick();
    arready_en = 1'b1;
    wait_drain("t6", 100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
